// File: rtl/mem_bank_arbiter_if.sv
// Requester-side and bank-side signals of one memory-bank arbiter.
// The arbiter takes the slave view; requesters plus the bank take the master view.
interface mem_bank_arbiter_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        Req;
    logic [NUM_REQ-1:0]        Wr;
    logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
    logic [NUM_REQ*DATA_W-1:0] ReqWData;
    logic [NUM_REQ-1:0]        Ack;
    logic [DATA_W-1:0]         RdData;
    logic [NUM_REQ-1:0]        Grant;
    logic                      Busy;
    logic [ADDR_W-1:0]         Address;
    logic [DATA_W-1:0]         WriteData;
    logic                      MemWrite;
    logic                      MemRead;
    logic [DATA_W-1:0]         ReadData;

    modport slave (
        input  Req, Wr, ReqAddr, ReqWData, ReadData,
        output Ack, RdData, Grant, Busy, Address, WriteData, MemWrite, MemRead
    );

    modport master (
        output Req, Wr, ReqAddr, ReqWData, ReadData,
        input  Ack, RdData, Grant, Busy, Address, WriteData, MemWrite, MemRead
    );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Four-way arbiter serialising single-byte accesses onto one 256x8 bank (IDLE/ACCESS/ACK).
// Define ARB_FIXED_PRI_EN for fixed priority (requester 0 highest); default is round-robin.
module mem_bank_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mem_bank_arbiter_if.slave    bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t                           state;
    logic [PTR_W-1:0]                 gidx;
    logic [NUM_REQ-1:0]               grant_q, ack_q;
    logic                             busy_q, mw_q, mr_q;
    logic [ADDR_W-1:0]                addr_q;
    logic [DATA_W-1:0]                wdata_q, rd_q;

    logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata;
    logic [PTR_W-1:0]                 base, win;
    logic                             win_vld;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_addr[i]  = bus.ReqAddr[i*ADDR_W +: ADDR_W];
        assign req_wdata[i] = bus.ReqWData[i*DATA_W +: DATA_W];
    end

`ifdef ARB_FIXED_PRI_EN
    assign base = '0;
`else
    logic [PTR_W-1:0] ptr;
    // Pointer moves past the last owner once its access completes.
    always_ff @(posedge Clk) begin
        if (Reset)
            ptr <= '0;
        else if (state == ACK)
            ptr <= gidx + 1'b1;
    end
    assign base = ptr;
`endif

    // Highest offset first so the requester nearest to base overrides.
    always_comb begin
        logic [PTR_W-1:0] idx;
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            idx = base + PTR_W'(k);
            if (bus.Req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            gidx    <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            mw_q    <= 1'b0;
            mr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= '0;
                    if (win_vld) begin
                        gidx    <= win;
                        grant_q <= NUM_REQ'(1) << win;
                        addr_q  <= req_addr[win];
                        wdata_q <= req_wdata[win];
                        mw_q    <= bus.Wr[win];
                        mr_q    <= ~bus.Wr[win];
                        busy_q  <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mr_q)
                        rd_q <= bus.ReadData;
                    mw_q  <= 1'b0;
                    mr_q  <= 1'b0;
                    ack_q <= grant_q;
                    state <= ACK;
                end
                ACK: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Ack       = ack_q;
    assign bus.Grant     = grant_q;
    assign bus.Busy      = busy_q;
    assign bus.RdData    = rd_q;
    assign bus.Address   = addr_q;
    assign bus.WriteData = wdata_q;
    // Enables are masked by Reset so an abandoned write never reaches the bank.
    assign bus.MemWrite  = mw_q & ~Reset;
    assign bus.MemRead   = mr_q & ~Reset;
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Scoreboard bench for mem_bank_arbiter with a behavioural 256x8 bank attached.
module tb_mem_bank_arbiter;
    logic Clk = 1'b0;
    logic Reset;
    logic mem_init;
    int   checks = 0;
    int   failures = 0;

    mem_bank_arbiter_if bus ();
    mem_bank_arbiter dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    typedef struct { int id; logic [7:0] data; } exp_t;
    exp_t exp_q[$];

    logic [7:0] mem [256];

    function automatic logic [7:0] init_val(input int a);
        case (a)
            'h2A:    return 8'h5C;
            'h80:    return 8'h00;
            'h05:    return 8'hE1;
            'h06:    return 8'h1E;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    assign bus.ReadData = mem[bus.Address];

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        end else if (bus.MemWrite) begin
            mem[bus.Address] = bus.WriteData;
        end
    end

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic drive(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
        bus.Req[i] = 1'b1;
        bus.Wr[i]  = wr;
        bus.ReqAddr[i*8 +: 8]  = a;
        bus.ReqWData[i*8 +: 8] = d;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        mem_init = 1'b1;
        bus.Req = '0; bus.Wr = '0; bus.ReqAddr = '0; bus.ReqWData = '0;
        repeat (2) cyc();
        mem_init = 1'b0;
        checks++;
        if ({bus.Ack, bus.Grant, bus.Busy, bus.RdData, bus.MemWrite, bus.MemRead, bus.Address, bus.WriteData} !== '0) begin
            failures++;
            $display("FAIL reset_vals ack=%b grant=%b busy=%b rd=%h mw=%b mr=%b addr=%h wd=%h want all zero",
                     bus.Ack, bus.Grant, bus.Busy, bus.RdData, bus.MemWrite, bus.MemRead, bus.Address, bus.WriteData);
        end
        Reset = 1'b0;
        cyc();
        checks++;
        if ({bus.Busy, bus.Grant} !== 5'b0) begin
            failures++;
            $display("FAIL idle_no_req busy=%b grant=%b want 0/0000", bus.Busy, bus.Grant);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        drive(1, 1'b0, 8'h2A, 8'h00);
        exp_q.push_back('{1, 8'h5C});
        cyc();
        checks++;
        if (bus.MemRead !== 1'b1 || bus.MemWrite !== 1'b0 || bus.Address !== 8'h2A || bus.Grant !== 4'b0010 || bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL rd_access mr=%b mw=%b addr=%h grant=%b busy=%b want 1/0/2a/0010/1",
                     bus.MemRead, bus.MemWrite, bus.Address, bus.Grant, bus.Busy);
        end
        cyc();
        checks++;
        e = exp_q.pop_front();
        if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data || bus.MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL rd_ack ack=%b rd=%h mw=%b want %b/%h/0", bus.Ack, bus.RdData, bus.MemWrite, 4'(1 << e.id), e.data);
        end
        bus.Req = '0;
        cyc();
        checks++;
        if (bus.Ack !== 4'b0 || bus.Busy !== 1'b0 || bus.Grant !== 4'b0 || bus.RdData !== 8'h5C) begin
            failures++;
            $display("FAIL rd_after ack=%b busy=%b grant=%b rd=%h want 0000/0/0000/5c", bus.Ack, bus.Busy, bus.Grant, bus.RdData);
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        int   mw_cnt = 0;
        drive(2, 1'b1, 8'h10, 8'hA7);
        exp_q.push_back('{2, 8'h5C});
        cyc();
        mw_cnt += int'(bus.MemWrite);
        checks++;
        if (bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0 || bus.Address !== 8'h10 || bus.WriteData !== 8'hA7) begin
            failures++;
            $display("FAIL wr_access mw=%b mr=%b addr=%h wd=%h want 1/0/10/a7", bus.MemWrite, bus.MemRead, bus.Address, bus.WriteData);
        end
        cyc();
        mw_cnt += int'(bus.MemWrite);
        checks++;
        e = exp_q.pop_front();
        if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data) begin
            failures++;
            $display("FAIL wr_ack ack=%b rd=%h want %b/%h", bus.Ack, bus.RdData, 4'(1 << e.id), e.data);
        end
        bus.Wr[2] = 1'b0;
        exp_q.push_back('{2, 8'hA7});
        cyc();
        mw_cnt += int'(bus.MemWrite);
        cyc();
        mw_cnt += int'(bus.MemWrite);
        checks++;
        if (bus.MemRead !== 1'b1 || bus.Address !== 8'h10) begin
            failures++;
            $display("FAIL rdback_access mr=%b addr=%h want 1/10", bus.MemRead, bus.Address);
        end
        cyc();
        mw_cnt += int'(bus.MemWrite);
        checks++;
        e = exp_q.pop_front();
        if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data) begin
            failures++;
            $display("FAIL rdback_ack ack=%b rd=%h want %b/%h", bus.Ack, bus.RdData, 4'(1 << e.id), e.data);
        end
        bus.Req = '0;
        cyc();
        mw_cnt += int'(bus.MemWrite);
        checks++;
        if (mw_cnt != 1) begin
            failures++;
            $display("FAIL memwrite_pulses got %0d want 1", mw_cnt);
        end
    endtask

`ifndef ARB_FIXED_PRI_EN
    task automatic test_contention();
        exp_t e;
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'(8'h40 + i), 8'h00);
        for (int k = 0; k < 8; k++) exp_q.push_back('{k % 4, init_val(8'h40 + k % 4)});
        cyc();
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            checks++;
            if (bus.Grant !== 4'(1 << (k % 4)) || bus.Busy !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant k=%0d grant=%b busy=%b want %b/1", k, bus.Grant, bus.Busy, 4'(1 << (k % 4)));
            end
            cyc();
            checks++;
            e = exp_q.pop_front();
            if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data) begin
                failures++;
                $display("FAIL rr_ack k=%0d ack=%b rd=%h want %b/%h", k, bus.Ack, bus.RdData, 4'(1 << e.id), e.data);
            end
            if (k == 7) bus.Req = '0;
            cyc();
            checks++;
            if (bus.Grant !== 4'b0 || bus.Ack !== 4'b0 || bus.Busy !== 1'b0) begin
                failures++;
                $display("FAIL rr_idle k=%0d grant=%b ack=%b busy=%b want 0000/0000/0", k, bus.Grant, bus.Ack, bus.Busy);
            end
        end
    endtask
`else
    task automatic test_contention();
        exp_t e;
        int   c;
        Reset = 1'b1;
        drive(0, 1'b0, 8'h40, 8'h00);
        drive(3, 1'b0, 8'h43, 8'h00);
        for (int k = 0; k < 3; k++) exp_q.push_back('{0, init_val(8'h40)});
        cyc();
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            cyc();
            checks++;
            e = exp_q.pop_front();
            if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data) begin
                failures++;
                $display("FAIL fp_ack k=%0d ack=%b rd=%h want %b/%h", k, bus.Ack, bus.RdData, 4'(1 << e.id), e.data);
            end
            if (k == 2) bus.Req[0] = 1'b0;
            cyc();
        end
        exp_q.push_back('{3, init_val(8'h43)});
        c = 0;
        while (c < 3 && bus.Ack == 4'b0) begin cyc(); c++; end
        checks++;
        e = exp_q.pop_front();
        if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data) begin
            failures++;
            $display("FAIL fp_low_ack ack=%b rd=%h want %b/%h", bus.Ack, bus.RdData, 4'(1 << e.id), e.data);
        end
        bus.Req = '0;
        repeat (2) cyc();
    endtask
`endif

    task automatic test_reset_mid_write();
        exp_t e;
        drive(1, 1'b0, 8'h2A, 8'h00);
        exp_q.push_back('{1, 8'h5C});
        cyc();
        cyc();
        checks++;
        e = exp_q.pop_front();
        if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data) begin
            failures++;
            $display("FAIL pre_rd_ack ack=%b rd=%h want %b/%h", bus.Ack, bus.RdData, 4'(1 << e.id), e.data);
        end
        bus.Req = '0;
        cyc();
        drive(2, 1'b1, 8'h80, 8'hFF);
        cyc();
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.MemWrite !== 1'b0 || bus.Address !== 8'h80) begin
            failures++;
            $display("FAIL rst_gate mw=%b addr=%h want 0/80", bus.MemWrite, bus.Address);
        end
        cyc();
        checks++;
        if ({bus.Ack, bus.Grant, bus.Busy, bus.RdData, bus.MemWrite, bus.MemRead, bus.Address, bus.WriteData} !== '0
            || mem[8'h80] !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid ack=%b grant=%b busy=%b rd=%h addr=%h wd=%h bank80=%h want zeros, bank80=00",
                     bus.Ack, bus.Grant, bus.Busy, bus.RdData, bus.Address, bus.WriteData, mem[8'h80]);
        end
        bus.Wr[2] = 1'b0;
        drive(0, 1'b0, 8'h2A, 8'h00);
        exp_q.push_back('{0, 8'h5C});
        exp_q.push_back('{2, 8'h00});
        Reset = 1'b0;
        cyc();
        checks++;
        if (bus.Grant !== 4'b0001) begin
            failures++;
            $display("FAIL rst_next_grant grant=%b want 0001", bus.Grant);
        end
        cyc();
        checks++;
        e = exp_q.pop_front();
        if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data) begin
            failures++;
            $display("FAIL rst_r0_ack ack=%b rd=%h want %b/%h", bus.Ack, bus.RdData, 4'(1 << e.id), e.data);
        end
        bus.Req[0] = 1'b0;
        cyc();
        cyc();
        cyc();
        checks++;
        e = exp_q.pop_front();
        if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data) begin
            failures++;
            $display("FAIL rst_bank80 ack=%b rd=%h want %b/%h", bus.Ack, bus.RdData, 4'(1 << e.id), e.data);
        end
        bus.Req = '0;
        cyc();
    endtask

    task automatic test_busy_change();
        exp_t e;
        drive(0, 1'b0, 8'h05, 8'h00);
        exp_q.push_back('{0, 8'hE1});
        cyc();
        bus.ReqAddr[7:0] = 8'h06;
        #1;
        checks++;
        if (bus.Address !== 8'h05 || bus.MemRead !== 1'b1) begin
            failures++;
            $display("FAIL busy_addr addr=%h mr=%b want 05/1", bus.Address, bus.MemRead);
        end
        cyc();
        checks++;
        e = exp_q.pop_front();
        if (bus.Ack !== 4'(1 << e.id) || bus.RdData !== e.data || bus.Address !== 8'h05) begin
            failures++;
            $display("FAIL busy_ack ack=%b rd=%h addr=%h want %b/%h/05", bus.Ack, bus.RdData, bus.Address, 4'(1 << e.id), e.data);
        end
        bus.Req = '0;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_reset_mid_write();
        test_busy_change();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
